// File: rtl/qspi_pkg.sv
// qspi_pkg: constants and encodings shared by the QSPI receive path.
//   RX_DATA_BITS_DEF : default width of one received word
//   phase_e / dir_e  : transfer phase and direction encodings; the receive
//                      handshake is enabled during PHASE_DATA with DIR_READ
//   DROP_CNT_W       : width of the dropped-word counter
package qspi_pkg;

  localparam int RX_DATA_BITS_DEF = 32;
  localparam int DROP_CNT_W       = 8;

  typedef enum logic [1:0] {
    PHASE_CMD   = 2'd0,
    PHASE_ADDR  = 2'd1,
    PHASE_DUMMY = 2'd2,
    PHASE_DATA  = 2'd3
  } phase_e;

  typedef enum logic {
    DIR_WRITE = 1'b0,
    DIR_READ  = 1'b1
  } dir_e;

endpackage

// File: rtl/qspi_rx_fifo.sv
// qspi_rx_fifo: synchronous first-word-fall-through FIFO for received words.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear of pointers and count (wins over push/pop)
//   push, din    : write din at the tail (caller guarantees room or a same-cycle pop)
//   pop          : advance the head (caller guarantees count != 0)
//   dout         : oldest word, forced to 0 while empty
//   count        : number of stored words (registered)
module qspi_rx_fifo #(
  parameter int DATA_BITS = 32,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_BITS-1:0]         din,
  output logic [DATA_BITS-1:0]         dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;

  // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; emptiness is tracked solely by count.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= din;
  end

  // Masking by count keeps dout at 0 during reset and when empty.
  assign dout = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/read_handshake.sv
// read_handshake: buffers received QSPI words toward firmware/DMA with a
// valid/ready handshake, flags dropped words and optionally counts them.
// Optional feature macro: READ_HANDSHAKE_DROP_CNT_EN (enables drop_count).
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   enable              : high during PHASE_DATA with DIR_READ; gates store_data
//   clr                 : synchronous clear of buffer, overflow and drop_count
//   data_in, store_data : completed word and its single-cycle strobe
//   rx_ready            : consumer accepts the head word this cycle
//   rx_valid, rx_data   : head word valid / oldest buffered word
//   level               : words buffered
//   overflow            : sticky, a word was dropped
//   drop_count          : saturating dropped-word count (0 when feature disabled)
module read_handshake
  import qspi_pkg::*;
#(
  parameter int DATA_BITS = RX_DATA_BITS_DEF,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         clr,
  input  logic [DATA_BITS-1:0]         data_in,
  input  logic                         store_data,
  input  logic                         rx_ready,
  output logic                         rx_valid,
  output logic [DATA_BITS-1:0]         rx_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic [DROP_CNT_W-1:0]        drop_count
);

  localparam int              LW       = $clog2(DEPTH+1);
  localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);

  logic wr_req;
  logic pop;
  logic push;
  logic drop;

  assign wr_req   = enable & store_data;
  assign rx_valid = (level != '0);
  assign pop      = rx_valid & rx_ready;
  // A same-cycle pop frees the slot, so a full buffer still accepts the word.
  assign push     = wr_req & ((level != FULL_LVL) | pop);
  assign drop     = wr_req & (level == FULL_LVL) & ~pop;

  qspi_rx_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .push    (push),
    .pop     (pop),
    .din     (data_in),
    .dout    (rx_data),
    .count   (level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   overflow <= 1'b0;
    else if (clr)   overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
  end

`ifdef READ_HANDSHAKE_DROP_CNT_EN
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [DROP_CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   drop_cnt_q <= '0;
    else if (clr)   drop_cnt_q <= '0;
    else if (drop)  drop_cnt_q <= sat_inc(drop_cnt_q);
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_read_handshake.sv
module tb_read_handshake;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] data_in = '0;
  logic        store_data = 1'b0;
  logic        rx_ready = 1'b0;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic [2:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;

  int total = 0;
  int passed = 0;

  // Behavioural model: a queue of words plus sticky flag and drop tally.
  logic [31:0] mq[$];
  logic        m_ovf = 1'b0;
  int          m_drops = 0;

  read_handshake #(.DATA_BITS(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .clr        (clr),
    .data_in    (data_in),
    .store_data (store_data),
    .rx_ready   (rx_ready),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  function automatic int exp_dc(input int n);
`ifdef READ_HANDSHAKE_DROP_CNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Model update at each active edge from the specification's rules.
  always @(posedge clk) begin
    if (reset_n) begin
      if (clr) begin
        mq.delete();
        m_ovf = 1'b0;
        m_drops = 0;
      end else begin
        bit do_pop, full;
        full   = (mq.size() == DEPTH);
        do_pop = (mq.size() != 0) && rx_ready;
        if (do_pop) void'(mq.pop_front());
        if (enable && store_data) begin
          if (!full || do_pop) mq.push_back(data_in);
          else begin
            m_ovf = 1'b1;
            m_drops++;
          end
        end
      end
    end
  end

  always @(negedge reset_n) begin
    mq.delete();
    m_ovf = 1'b0;
    m_drops = 0;
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_valid", {31'd0, rx_valid}, {31'd0, mq.size() != 0});
    chk("cmp_level", {29'd0, level}, mq.size());
    chk("cmp_overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("cmp_drop_count", {24'd0, drop_count}, exp_dc(m_drops));
    if (mq.size() != 0) chk("cmp_data", rx_data, mq[0]);
  end

  // Inputs are applied 1 time unit after an edge; returns 1 unit after the next edge.
  task automatic step(input logic en, input logic st, input logic [31:0] d, input logic rdy);
    enable = en; store_data = st; data_in = d; rx_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1'b1, 1'b0, 32'd0, 1'b0);
    clr = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_data", rx_data, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_drop", {24'd0, drop_count}, 32'd0);
    reset_n = 1'b1;

    // First push right after reset; one-cycle latency
    step(1'b1, 1'b1, 32'hA5A5A5A5, 1'b0);
    chk("lat_valid", {31'd0, rx_valid}, 32'd1);
    chk("lat_data", rx_data, 32'hA5A5A5A5);
    chk("lat_level", {29'd0, level}, 32'd1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("pop_empty", {29'd0, level}, 32'd0);

    // Overflow on fifth push, then in-order drain
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, i, 1'b0);
    chk("ovf_level", {29'd0, level}, 32'd4);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_drop", {24'd0, drop_count}, exp_dc(1));
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", rx_data, i);
      step(1'b1, 1'b0, 32'd0, 1'b1);
    end
    chk("drain_valid", {31'd0, rx_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    do_clr();
    chk("clr_overflow", {31'd0, overflow}, 32'd0);
    chk("clr_drop", {24'd0, drop_count}, 32'd0);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h11 + i, 1'b0);
    step(1'b1, 1'b1, 32'h9, 1'b1);
    chk("fullpp_level", {29'd0, level}, 32'd4);
    chk("fullpp_ovf", {31'd0, overflow}, 32'd0);
    chk("fullpp_head", rx_data, 32'h12);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("fullpp_fifth", rx_data, 32'h9);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("fullpp_empty", {31'd0, rx_valid}, 32'd0);

    // Store with enable low is ignored; enable drop does not flush
    step(1'b0, 1'b1, 32'hDEAD, 1'b0);
    chk("dis_level", {29'd0, level}, 32'd0);
    chk("dis_ovf", {31'd0, overflow}, 32'd0);
    step(1'b1, 1'b1, 32'h77, 1'b0);
    step(1'b1, 1'b1, 32'h88, 1'b0);
    repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("hold_level", {29'd0, level}, 32'd2);
    chk("hold_w0", rx_data, 32'h77);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("hold_w1", rx_data, 32'h88);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("hold_empty", {31'd0, rx_valid}, 32'd0);

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h300 + i, 1'b0);
    enable = 1'b0; store_data = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, rx_valid}, 32'd0);
    chk("arst_level", {29'd0, level}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(1'b1, 1'b1, 32'hBEEF, 1'b0);
    chk("post_arst_push", rx_data, 32'hBEEF);
    do_clr();

    // Many drops: saturation (or constant 0 when the counter is absent)
    for (int i = 0; i < 304; i++) step(1'b1, 1'b1, i, 1'b0);
    chk("sat_drop", {24'd0, drop_count}, exp_dc(300));
    chk("sat_ovf", {31'd0, overflow}, 32'd1);
    chk("sat_head", rx_data, 32'd0);
    do_clr();
    chk("sat_clr_drop", {24'd0, drop_count}, 32'd0);

    // Randomised traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      clr = ($urandom_range(0, 60) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0);
    end
    clr = 1'b0;
    repeat (2) step(1'b0, 1'b0, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
